// File: rtl/fadd_dual_pack.sv
// Packs single-precision operand pairs two-per-word for a dual-mode adder;
// doubles pass through whole, a lone single is issued half-empty on timeout, flush or a following double.
module fadd_dual_pack #(
  parameter int TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_prec,
  input  logic [63:0] i_A,
  input  logic [63:0] i_B,
  input  logic [3:0]  i_tag,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_mode,
  output logic [63:0] o_A,
  output logic [63:0] o_B,
  output logic [1:0]  o_lanes,
  output logic [7:0]  o_tag,
  output logic [1:0]  o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and payload stable until that edge.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_DPEND = 2'd2;
  localparam logic [7:0] T_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]  state, state_n;
  logic [7:0]  timer, timer_n;
  logic [63:0] hold_a, hold_b;
  logic [3:0]  hold_tag;
  logic        capture;

  logic        load;
  logic        nxt_mode;
  logic [63:0] nxt_a, nxt_b;
  logic [1:0]  nxt_lanes;
  logic [7:0]  nxt_tag;

  logic slot_free, acc;

  assign slot_free = !o_valid || i_ready;
  assign o_ready   = !i_clr && slot_free && (state != S_DPEND);
  assign acc       = i_valid && o_ready;
  assign o_state   = state;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    capture   = 1'b0;
    load      = 1'b0;
    nxt_mode  = 1'b0;
    nxt_a     = 64'h0;
    nxt_b     = 64'h0;
    nxt_lanes = 2'b00;
    nxt_tag   = 8'h00;
    case (state)
      S_EMPTY: begin
        if (acc && i_prec) begin
          load      = 1'b1;
          nxt_mode  = 1'b1;
          nxt_a     = i_A;
          nxt_b     = i_B;
          nxt_lanes = 2'b11;
          nxt_tag   = {i_tag, i_tag};
        end else if (acc) begin
          capture = 1'b1;
          timer_n = 8'h00;
          state_n = S_HALF;
        end
      end
      S_HALF: begin
        // The held single always rides the upper lane.
        if (acc && !i_prec) begin
          load      = 1'b1;
          nxt_a     = {hold_a[31:0], i_A[31:0]};
          nxt_b     = {hold_b[31:0], i_B[31:0]};
          nxt_lanes = 2'b11;
          nxt_tag   = {hold_tag, i_tag};
          state_n   = S_EMPTY;
        end else if (acc || (slot_free && (timer == T_LAST || i_flush))) begin
          load      = 1'b1;
          nxt_a     = {hold_a[31:0], 32'h0};
          nxt_b     = {hold_b[31:0], 32'h0};
          nxt_lanes = 2'b10;
          nxt_tag   = {hold_tag, 4'h0};
          capture   = acc;
          state_n   = acc ? S_DPEND : S_EMPTY;
        end else if (timer != T_LAST) begin
          timer_n = timer + 8'd1;
        end
      end
      S_DPEND: begin
        if (slot_free) begin
          load      = 1'b1;
          nxt_mode  = 1'b1;
          nxt_a     = hold_a;
          nxt_b     = hold_b;
          nxt_lanes = 2'b11;
          nxt_tag   = {hold_tag, hold_tag};
          state_n   = S_EMPTY;
        end
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state    <= S_EMPTY;
      timer    <= 8'h00;
      hold_a   <= 64'h0;
      hold_b   <= 64'h0;
      hold_tag <= 4'h0;
      o_valid  <= 1'b0;
      o_mode   <= 1'b0;
      o_A      <= 64'h0;
      o_B      <= 64'h0;
      o_lanes  <= 2'b00;
      o_tag    <= 8'h00;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (capture) begin
        hold_a   <= i_A;
        hold_b   <= i_B;
        hold_tag <= i_tag;
      end
      if (load) begin
        o_valid <= 1'b1;
        o_mode  <= nxt_mode;
        o_A     <= nxt_a;
        o_B     <= nxt_b;
        o_lanes <= nxt_lanes;
        o_tag   <= nxt_tag;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fadd_dual_pack.sv
// Bench for fadd_dual_pack: directed scenarios with literal expectations plus a
// randomized run scored against a transaction-level packing model.
module tb_fadd_dual_pack;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        i_clr, i_valid, i_prec, i_flush, i_ready;
  logic [63:0] i_A, i_B;
  logic [3:0]  i_tag;
  logic        o_ready, o_valid, o_mode;
  logic [63:0] o_A, o_B;
  logic [1:0]  o_lanes, o_state;
  logic [7:0]  o_tag;

  fadd_dual_pack #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_clr(i_clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_prec(i_prec), .i_A(i_A), .i_B(i_B), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_mode(o_mode), .o_A(o_A),
    .o_B(o_B), .o_lanes(o_lanes), .o_tag(o_tag), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: words expected on the output, in issue order, as {mode,A,B,lanes,tag}.
  logic [138:0] exp_q[$];
  logic         pend;
  logic [63:0]  pend_a, pend_b;
  logic [3:0]   pend_tag;
  int           age;
  logic         last_rdy;
  int           passed = 0;
  int           total  = 0;

  task automatic check(input string name, input logic [138:0] got, input logic [138:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [138:0] w_double(input logic [63:0] a, b, input logic [3:0] t);
    return {1'b1, a, b, 2'b11, t, t};
  endfunction

  function automatic logic [138:0] w_pair(input logic [63:0] ua, ub, la, lb, input logic [3:0] ut, lt);
    return {1'b0, ua[31:0], la[31:0], ub[31:0], lb[31:0], 2'b11, ut, lt};
  endfunction

  function automatic logic [138:0] w_lone(input logic [63:0] ua, ub, input logic [3:0] ut);
    return {1'b0, ua[31:0], 32'h0, ub[31:0], 32'h0, 2'b10, ut, 4'h0};
  endfunction

  // One clock: drive inputs, check o_ready, advance the model, then check outputs after the edge.
  task automatic cycle(input logic v, p, input logic [63:0] a, b, input logic [3:0] t,
                       input logic fl, rd, cl);
    logic ov, exp_rdy, acc, slot;
    i_valid = v; i_prec = p; i_A = a; i_B = b; i_tag = t;
    i_flush = fl; i_ready = rd; i_clr = cl;
    #1;
    ov       = o_valid;
    last_rdy = o_ready;
    exp_rdy  = !cl && (!ov || rd) && (exp_q.size() < 2);
    check("o_ready", {138'h0, last_rdy}, {138'h0, exp_rdy});
    if (cl) begin
      exp_q.delete();
      pend = 1'b0;
      age  = 0;
    end else begin
      acc  = v && exp_rdy;
      slot = !ov || rd;
      if (ov && rd && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc && !p) begin
        if (pend) begin
          exp_q.push_back(w_pair(pend_a, pend_b, a, b, pend_tag, t));
          pend = 1'b0;
        end else begin
          pend = 1'b1; pend_a = a; pend_b = b; pend_tag = t; age = 0;
        end
      end else if (acc) begin
        if (pend) exp_q.push_back(w_lone(pend_a, pend_b, pend_tag));
        pend = 1'b0;
        exp_q.push_back(w_double(a, b, t));
      end else if (pend) begin
        if (slot && (age == TIMEOUT - 1 || fl)) begin
          exp_q.push_back(w_lone(pend_a, pend_b, pend_tag));
          pend = 1'b0;
        end else if (age < TIMEOUT - 1) begin
          age++;
        end
      end
    end
    @(posedge clk);
    #1;
    check("o_valid", {138'h0, o_valid}, {138'h0, exp_q.size() != 0});
    if (o_valid && exp_q.size() != 0)
      check("word", {o_mode, o_A, o_B, o_lanes, o_tag}, exp_q[0]);
    if (cl) check("reset_word", {o_mode, o_A, o_B, o_lanes, o_tag}, 139'h0);
  endtask

  task automatic idle(input logic rd);
    cycle(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, rd, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    pend = 1'b0; age = 0; last_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_valid", {138'h0, o_valid}, 139'h0);
    check("rst_state", {137'h0, o_state}, 139'h0);

    // Two singles pair into one word, first arrival in the upper lane
    cycle(1'b1, 1'b0, 64'h3F800000, 64'h40000000, 4'h1, 1'b0, 1'b1, 1'b0);
    check("pair_wait", {138'h0, o_valid}, 139'h0);
    cycle(1'b1, 1'b0, 64'h40400000, 64'h40800000, 4'h2, 1'b0, 1'b1, 1'b0);
    check("pair_A", {75'h0, o_A}, {75'h0, 64'h3F80000040400000});
    check("pair_B", {75'h0, o_B}, {75'h0, 64'h4000000040800000});
    check("pair_meta", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b0, 2'b11, 8'h12});
    idle(1'b1);

    // Lone single times out 8 cycles after acceptance
    cycle(1'b1, 1'b0, 64'h3F800000, 64'h40000000, 4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b1);
    check("lone_early", {138'h0, o_valid}, 139'h0);
    idle(1'b1);
    check("lone_meta", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b0, 2'b10, 8'h50});
    check("lone_low", {75'h0, o_A[31:0], o_B[31:0]}, 139'h0);
    idle(1'b1);

    // Single then double: lone single then double on consecutive cycles
    cycle(1'b1, 1'b0, 64'h3F800000, 64'h40000000, 4'h3, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 4'h7, 1'b0, 1'b1, 1'b0);
    check("sd_lone", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b0, 2'b10, 8'h30});
    idle(1'b1);
    check("dpend_ready", {138'h0, last_rdy}, 139'h0);
    check("sd_double", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b1, 2'b11, 8'h77});
    check("sd_double_A", {75'h0, o_A}, {75'h0, 64'h3FF0000000000000});
    idle(1'b1);

    // Reset mid-DPEND with output stalled, then a clean double
    cycle(1'b1, 1'b0, 64'h1, 64'h2, 4'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h3, 64'h4, 4'h6, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("stall_state", {137'h0, o_state}, {137'h0, 2'd2});
    cycle(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("clr_valid", {138'h0, o_valid}, 139'h0);
    check("clr_state", {137'h0, o_state}, 139'h0);
    cycle(1'b1, 1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'h9, 1'b0, 1'b1, 1'b0);
    check("post_clr", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b1, 2'b11, 8'h99});
    idle(1'b1);

    // Single plus flush in HALF pairs rather than issuing lone
    cycle(1'b1, 1'b0, 64'hA, 64'hB, 4'h1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 64'hC, 64'hD, 4'h2, 1'b1, 1'b1, 1'b0);
    check("flush_pair", {128'h0, o_valid, o_mode, o_lanes, o_tag}, {128'h0, 1'b1, 1'b0, 2'b11, 8'h12});
    idle(1'b1);

    // Randomized traffic with periodic downstream stalls
    for (int n = 0; n < 3000; n++) begin
      logic rd;
      rd = ((n % 40) >= 33) ? 1'b0 : ($urandom_range(0, 9) < 7);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0, rd, $urandom_range(0, 199) == 0);
    end

    for (int n = 0; n < 20; n++) idle(1'b1);
    check("drain", {138'h0, (exp_q.size() == 0) && !pend}, {138'h0, 1'b1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
